// File: rtl/cpu_pkg.sv
// Shared core definitions: opcode, condition-code and RUN/HALT state encodings.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned CC_W   = 3;
    localparam int unsigned OFF_W  = 9;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_XOR    = 4'b0010,
        OP_RED    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111,
        OP_LW     = 4'b1000,
        OP_SW     = 4'b1001,
        OP_LLB    = 4'b1010,
        OP_LHB    = 4'b1011,
        OP_B      = 4'b1100,
        OP_BR     = 4'b1101,
        OP_PCS    = 4'b1110,
        OP_HLT    = 4'b1111
    } opcode_e;

    typedef enum logic [CC_W-1:0] {
        CC_NE   = 3'b000,
        CC_EQ   = 3'b001,
        CC_GT   = 3'b010,
        CC_LT   = 3'b011,
        CC_GTE  = 3'b100,
        CC_LTE  = 3'b101,
        CC_OVFL = 3'b110,
        CC_UNC  = 3'b111
    } cond_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

endpackage

// File: rtl/pc_flag_unit_branch_cond.sv
// Combinational branch-condition evaluator over the latched N/Z/V flags.
module branch_cond
    import cpu_pkg::*;
(
    input  cond_e cond,
    input  logic  n,
    input  logic  z,
    input  logic  v,
    output logic  taken
);

    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_NE:   taken = ~z;
            CC_EQ:   taken = z;
            CC_GT:   taken = ~z & ~n;
            CC_LT:   taken = n;
            CC_GTE:  taken = z | (~z & ~n);
            CC_LTE:  taken = n | z;
            CC_OVFL: taken = v;
            CC_UNC:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_flag_unit.sv
// PC sequencing, flag latching and RUN/HALT control for the 16-bit core.
// Optional taken-branch counter enabled by BRANCH_CNT_EN.
module pc_flag_unit
    import cpu_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] instr,
    input  logic              alu_n,
    input  logic              alu_z,
    input  logic              alu_v,
    input  logic [DATA_W-1:0] rs_data,
    input  logic              stall,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pc_plus2,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_v,
    output logic              branch_taken,
    output logic              halt
`ifdef BRANCH_CNT_EN
    ,
    output logic [DATA_W-1:0] taken_count
`endif
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic              n_q, z_q, v_q;
    logic              n_d, z_d, v_d;
    logic              cond_true;
    logic              advance;
    logic [DATA_W-1:0] br_offset;
    logic [DATA_W-1:0] br_target;
    opcode_e           opcode;

    assign opcode    = opcode_e'(instr[15:12]);
    assign pc_plus2  = pc_q + DATA_W'(2);
    // Offset is a signed word count; scale to bytes.
    assign br_offset = {{(DATA_W-OFF_W-1){instr[OFF_W-1]}}, instr[OFF_W-1:0], 1'b0};
    assign br_target = pc_plus2 + br_offset;
    assign advance   = (state_q == ST_RUN) && !stall;

    branch_cond u_branch_cond (
        .cond  (cond_e'(instr[11:9])),
        .n     (n_q),
        .z     (z_q),
        .v     (v_q),
        .taken (cond_true)
    );

    assign branch_taken = (state_q == ST_RUN) && cond_true &&
                          ((opcode == OP_B) || (opcode == OP_BR));

    // Next-state, next-PC and flag write selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        n_d     = n_q;
        z_d     = z_q;
        v_d     = v_q;
        if (advance) begin
            case (opcode)
                OP_ADD, OP_SUB: begin
                    n_d = alu_n;
                    z_d = alu_z;
                    v_d = alu_v;
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: z_d = alu_z;
                default: ;
            endcase
            case (opcode)
                OP_B:    pc_d = cond_true ? br_target : pc_plus2;
                OP_BR:   pc_d = cond_true ? rs_data : pc_plus2;
                OP_HLT:  state_d = ST_HALT;
                default: pc_d = pc_plus2;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            n_q     <= n_d;
            z_q     <= z_d;
            v_q     <= v_d;
        end
    end

    assign pc     = pc_q;
    assign flag_n = n_q;
    assign flag_z = z_q;
    assign flag_v = v_q;
    assign halt   = (state_q == ST_HALT);

`ifdef BRANCH_CNT_EN
    logic [DATA_W-1:0] cnt_q;

    // Saturating count of branches actually taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (branch_taken && !stall && (cnt_q != {DATA_W{1'b1}})) begin
            cnt_q <= cnt_q + DATA_W'(1);
        end
    end

    assign taken_count = cnt_q;
`endif

endmodule

// File: tb/tb_pc_flag_unit.sv
// Self-checking bench for pc_flag_unit: directed vector table plus random run against a model.
module tb_pc_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        alu_n, alu_z, alu_v;
    logic [15:0] rs_data;
    logic        stall;
    logic [15:0] pc, pc_plus2;
    logic        flag_n, flag_z, flag_v;
    logic        branch_taken;
    logic        halt;
`ifdef BRANCH_CNT_EN
    logic [15:0] taken_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_flag_unit dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .alu_n        (alu_n),
        .alu_z        (alu_z),
        .alu_v        (alu_v),
        .rs_data      (rs_data),
        .stall        (stall),
        .pc           (pc),
        .pc_plus2     (pc_plus2),
        .flag_n       (flag_n),
        .flag_z       (flag_z),
        .flag_v       (flag_v),
        .branch_taken (branch_taken),
        .halt         (halt)
`ifdef BRANCH_CNT_EN
        ,
        .taken_count  (taken_count)
`endif
    );

    typedef struct {
        logic        rst;
        logic        stall;
        logic [15:0] instr;
        logic [2:0]  alu_nzv;
        logic [15:0] rs;
        logic        chk_tk;
        logic        exp_tk;
        logic [15:0] exp_pc;
        logic [2:0]  exp_nzv;
        logic        exp_halt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, sample combinational outputs, then clock the edge.
    logic tk_pre;
    logic [15:0] pp_pre;
    task automatic step(input logic r, input logic s, input logic [15:0] ins,
                        input logic [2:0] nzv, input logic [15:0] rs);
        rst     = r;
        stall   = s;
        instr   = ins;
        {alu_n, alu_z, alu_v} = nzv;
        rs_data = rs;
        #2;
        tk_pre = branch_taken;
        pp_pre = pc_plus2;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic [15:0] ins,
                                input logic [2:0] nzv, input logic [15:0] rs,
                                input logic ct, input logic et, input logic [15:0] epc,
                                input logic [2:0] enzv, input logic eh);
        vec_t t;
        t.rst = r; t.stall = s; t.instr = ins; t.alu_nzv = nzv; t.rs = rs;
        t.chk_tk = ct; t.exp_tk = et; t.exp_pc = epc; t.exp_nzv = enzv; t.exp_halt = eh;
        return t;
    endfunction

    // Reference model state.
    int          m_pc;
    logic        m_n, m_z, m_v, m_halt;
    int          m_cnt;

    function automatic logic cond_ok(input int cc, input logic n, input logic z, input logic v);
        case (cc)
            0: return !z;
            1: return z;
            2: return !z && !n;
            3: return n;
            4: return z || (!z && !n);
            5: return n || z;
            6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic model_taken(input logic [15:0] ins);
        int op;
        op = int'(ins[15:12]);
        return !m_halt && (op == 12 || op == 13) &&
               cond_ok(int'(ins[11:9]), m_n, m_z, m_v);
    endfunction

    task automatic model_edge(input logic r, input logic s, input logic [15:0] ins,
                              input logic [2:0] nzv, input logic [15:0] rs);
        int op, off;
        logic tk;
        op = int'(ins[15:12]);
        tk = model_taken(ins);
        if (r) begin
            m_pc = 0; m_n = 0; m_z = 0; m_v = 0; m_halt = 0; m_cnt = 0;
        end else if (!s && !m_halt) begin
            if (tk && m_cnt < 65535) m_cnt++;
            if (op == 0 || op == 1) {m_n, m_z, m_v} = nzv;
            else if (op == 2 || op == 4 || op == 5 || op == 6) m_z = nzv[1];
            off = int'(ins[8:0]);
            if (off >= 256) off -= 512;
            if (op == 15) m_halt = 1;
            else if (op == 12 && tk) m_pc = ((m_pc + 2 + off * 2) % 65536 + 65536) % 65536;
            else if (op == 13 && tk) m_pc = int'(rs);
            else m_pc = (m_pc + 2) % 65536;
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; instr = 16'h8000;
        alu_n = 0; alu_z = 0; alu_v = 0; rs_data = 16'h0;
        @(negedge clk);

        // Directed program: reset, sequencing, flags, B/BR, wrap, stall, halt.
        vecs.push_back(mk(1, 0, 16'h8000, 3'b000, 16'h0,    0, 0, 16'h0000, 3'b000, 0));
        vecs.push_back(mk(0, 0, 16'h8000, 3'b000, 16'h0,    1, 0, 16'h0002, 3'b000, 0));
        vecs.push_back(mk(0, 0, 16'h8000, 3'b000, 16'h0,    1, 0, 16'h0004, 3'b000, 0));
        vecs.push_back(mk(0, 0, 16'h8000, 3'b000, 16'h0,    1, 0, 16'h0006, 3'b000, 0));
        vecs.push_back(mk(0, 0, 16'h1000, 3'b010, 16'h0,    1, 0, 16'h0008, 3'b010, 0));
        vecs.push_back(mk(0, 0, 16'h2000, 3'b101, 16'h0,    1, 0, 16'h000A, 3'b000, 0));
        vecs.push_back(mk(0, 0, 16'h1000, 3'b010, 16'h0,    1, 0, 16'h000C, 3'b010, 0));
        vecs.push_back(mk(0, 0, 16'h8000, 3'b000, 16'h0,    1, 0, 16'h000E, 3'b010, 0));
        vecs.push_back(mk(0, 0, 16'h8000, 3'b000, 16'h0,    1, 0, 16'h0010, 3'b010, 0));
        vecs.push_back(mk(0, 0, 16'hC3FE, 3'b000, 16'h0,    1, 1, 16'h000E, 3'b010, 0));
        vecs.push_back(mk(0, 0, 16'h2000, 3'b000, 16'h0,    1, 0, 16'h0010, 3'b000, 0));
        vecs.push_back(mk(0, 0, 16'hC3FE, 3'b000, 16'h0,    1, 0, 16'h0012, 3'b000, 0));
        vecs.push_back(mk(0, 0, 16'hDE00, 3'b000, 16'hABCD, 1, 1, 16'hABCD, 3'b000, 0));
        vecs.push_back(mk(0, 0, 16'hDE00, 3'b000, 16'hFFFE, 1, 1, 16'hFFFE, 3'b000, 0));
        vecs.push_back(mk(0, 0, 16'h8000, 3'b000, 16'h0,    1, 0, 16'h0000, 3'b000, 0));
        vecs.push_back(mk(0, 1, 16'hCE04, 3'b111, 16'h0,    1, 1, 16'h0000, 3'b000, 0));
        vecs.push_back(mk(0, 1, 16'hCE04, 3'b111, 16'h0,    1, 1, 16'h0000, 3'b000, 0));
        vecs.push_back(mk(0, 0, 16'hCE04, 3'b000, 16'h0,    1, 1, 16'h000A, 3'b000, 0));
        vecs.push_back(mk(0, 0, 16'hCE0A, 3'b000, 16'h0,    1, 1, 16'h0020, 3'b000, 0));
        vecs.push_back(mk(0, 0, 16'hF000, 3'b000, 16'h0,    1, 0, 16'h0020, 3'b000, 1));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 16'h0000, 3'b111, 16'h0, 1, 0, 16'h0020, 3'b000, 1));
        vecs.push_back(mk(0, 0, 16'hCE04, 3'b111, 16'h0,    1, 0, 16'h0020, 3'b000, 1));
        vecs.push_back(mk(1, 0, 16'h0000, 3'b111, 16'h0,    1, 0, 16'h0000, 3'b000, 0));

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].instr, vecs[i].alu_nzv, vecs[i].rs);
            if (vecs[i].chk_tk) chk($sformatf("v%0d_taken", i), 16'(tk_pre), 16'(vecs[i].exp_tk));
            chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_flags", i), 16'({flag_n, flag_z, flag_v}), 16'(vecs[i].exp_nzv));
            chk($sformatf("v%0d_halt", i), 16'(halt), 16'(vecs[i].exp_halt));
        end

`ifdef BRANCH_CNT_EN
        // 3 taken, 1 not-taken (OVFL with V=0), 1 stalled taken.
        step(1, 0, 16'h8000, 3'b000, 16'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 16'hCE00, 3'b000, 16'h0);
        step(0, 0, 16'hCC00, 3'b000, 16'h0);
        step(0, 1, 16'hCE00, 3'b000, 16'h0);
        chk("cnt_three", taken_count, 16'd3);
        for (int i = 0; i < 65532; i++) step(0, 0, 16'hCE00, 3'b000, 16'h0);
        chk("cnt_max", taken_count, 16'hFFFF);
        step(0, 0, 16'hCE00, 3'b000, 16'h0);
        step(0, 0, 16'hDE00, 3'b000, 16'h1234);
        chk("cnt_sat", taken_count, 16'hFFFF);
        chk("cnt_sat_pc", pc, 16'h1234);
`endif

        // Randomized run against the reference model.
        step(1, 0, 16'h8000, 3'b000, 16'h0);
        model_edge(1, 0, 16'h8000, 3'b000, 16'h0);
        for (int i = 0; i < 3000; i++) begin
            logic        r, s;
            logic [15:0] ins, rs;
            logic [2:0]  nzv;
            logic        et;
            r   = ($urandom_range(0, 63) == 0);
            s   = ($urandom_range(0, 3) == 0);
            ins = 16'($urandom);
            if (ins[15:12] == 4'hF && $urandom_range(0, 7) != 0) ins[15:12] = 4'h8;
            nzv = 3'($urandom);
            rs  = 16'($urandom);
            et  = model_taken(ins);
            step(r, s, ins, nzv, rs);
            chk("rnd_taken", 16'(tk_pre), 16'(et));
            chk("rnd_pc_plus2", pp_pre, 16'((m_pc + 2) % 65536));
            model_edge(r, s, ins, nzv, rs);
            chk("rnd_pc", pc, 16'(m_pc));
            chk("rnd_flags", 16'({flag_n, flag_z, flag_v}), 16'({m_n, m_z, m_v}));
            chk("rnd_halt", 16'(halt), 16'(m_halt));
`ifdef BRANCH_CNT_EN
            chk("rnd_cnt", taken_count, 16'(m_cnt));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_flag_unit.md
# pc_flag_unit

Program-counter and condition-flag stage for the 16-bit single-cycle core, directly downstream of the ALU. It latches the N/Z/V flags the ALU produces, according to which opcode produced them, and evaluates B/BR branch conditions against the latched flags. It also sequences the PC (PC+2, PC-relative branch, register branch) and runs the RUN/HALT machine that stops fetch on HLT.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  16  instruction currently at `pc`; [15:12] opcode, [11:9] condition code, [8:0] branch offset.
- alu_n, alu_z, alu_v  input  1 each  ALU flag results for `instr`.
- rs_data  input  16  register-file read of rs, used as the BR target.
- stall  input  1  freezes all state while high.
- pc  output  16  current fetch address.
- pc_plus2  output  16  pc+2, combinational; this is the PCS writeback value.
- flag_n, flag_z, flag_v  output  1 each  latched flags.
- branch_taken  output  1  combinational; the current B/BR condition is true and the unit is in RUN.
- halt  output  1  high in the HALT state.
- taken_count  output  16  taken-branch counter; present only with BRANCH_CNT_EN.

## Operation
- Opcodes: ADD 0000, SUB 0001, XOR 0010, RED 0011, SLL 0100, SRA 0101, ROR 0110, PADDSB 0111, LW 1000, SW 1001, LLB 1010, LHB 1011, B 1100, BR 1101, PCS 1110, HLT 1111.
- Flag update, when in RUN and not stalled:
  - ADD, SUB: write N, Z and V from alu_*.
  - XOR, SLL, SRA, ROR: write Z only.
  - All other opcodes: flags unchanged.
- Condition codes on the latched flags:
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GTE: Z=1, or Z=0 and N=0.
  - 101 LTE: N=1 or Z=1.
  - 110 OVFL: V=1.
  - 111: always taken.
- Next PC, in RUN:
  - B taken: pc+2 + (sign-extended offset[8:0] << 1).
  - BR taken: rs_data.
  - HLT: pc (held).
  - Otherwise, including a not-taken branch: pc+2.
- Arithmetic is 16-bit modulo 2^16. Wrap-around is silent; there is no error output.
- State machine (two states):
  - RUN to HALT: an HLT opcode is seen while not stalled.
  - HALT to HALT: unconditional. In HALT, `instr` is ignored and pc, the flags and the counter are frozen.
  - Only rst leaves HALT.
- stall=1 overrides everything. No PC, flag, state or counter change, and branch_taken is still driven combinationally.

## Timing
- Reset values: pc=RESET_PC, flags all 0, halt=0, state RUN, taken_count=0. rst has priority over stall and over any opcode.
- Flags written at edge k are visible to the branch evaluated in cycle k+1. A branch never reads flags produced in its own cycle; branches write no flags, so there is no same-cycle conflict.
- PC latency is one cycle: the next-PC computed in cycle k appears on pc after edge k.
- HLT seen in cycle k: halt=1 after edge k, and pc stays equal to the HLT instruction's address.
- rst asserted while in HALT returns to RUN at RESET_PC on the next edge.

## Configuration
- BRANCH_CNT_EN defined:
  - Adds the `taken_count` port.
  - Increments on each edge where branch_taken=1, stall=0 and the state is RUN.
  - Saturates at 16'hFFFF; reset clears it to 0.
- BRANCH_CNT_EN undefined: the port and its register are absent. All other behaviour is identical.

## Structure
- The shared package `cpu_pkg` holds:
  - the opcode enum (4-bit),
  - the condition-code enum (3-bit),
  - the state enum for RUN/HALT.
- The ALU uses the same opcode enum from this package.
- One sub-module: `branch_cond`, a combinational block taking the condition code and the N/Z/V flags and returning `taken`. It is instantiated once.

## Test plan
- Reset and sequencing: assert rst, then run 3 non-branch instructions with stall=0 -> pc = 0x0000, 0x0002, 0x0004, 0x0006; flags=000; halt=0.
- Flag update rules: SUB with alu_n/z/v=0/1/0, then XOR with alu_n/z/v=1/0/1 -> after SUB flags N/Z/V=0/1/0; after XOR flags N/Z/V=0/0/0 (Z written, N and V kept).
- B EQ, taken and not taken: Z=1, pc=0x0010, B EQ offset 9'h1FE (-2) -> pc=0x000E with branch_taken=1. Repeat with Z=0 -> pc=0x0012.
- BR unconditional and PC wrap: BR ccc=111, rs_data=0xABCD -> pc=0xABCD. Separately, pc=0xFFFE with a non-branch instruction -> pc=0x0000.
- Stall and halt: stall=1 for 2 cycles during a B -> pc and flags unchanged. Then HLT at pc=0x0020 -> halt=1, pc stays 0x0020 for 5 cycles despite an ADD on instr. rst -> pc=0x0000, halt=0.
- With BRANCH_CNT_EN: 3 taken branches, 1 not taken and 1 stalled taken branch -> taken_count=3. Preload near the limit and take more branches -> count holds at 0xFFFF.
